// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and byte type
package uart_pkg;

  localparam int unsigned CLK_IN     = 40000000;
  localparam int unsigned BAUD_RATE  = 115200;
  localparam int unsigned UART_WIDTH = 8;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FWFT byte FIFO feeding the UART transmitter with sticky overflow
// Optional level/almost_full outputs under `define UART_TX_FIFO_LEVEL_EN
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_WIDTH,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ready,
  output logic             overflow,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [AW:0]      level,
  output logic             almost_full,
`endif
  input  logic             clr_overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Flags come from the registered count only, so a same-cycle pop never frees a slot for a push.
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push     = wr_en & ~full;
  assign pop      = tx_ready & ~empty;
  assign wr_ready = ~full;
  assign tx_valid = ~empty;
  assign tx_data  = empty ? '0 : mem[rd_ptr];

`ifdef UART_TX_FIFO_LEVEL_EN
  localparam logic [AW:0] ALMOST_CNT = (AW+1)'(DEPTH - 2);
  assign level       = count;
  assign almost_full = (count >= ALMOST_CNT);
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // A new overflow outranks a simultaneous clear so the event is never lost.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       overflow;
  logic       clr_overflow;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] level;
  logic       almost_full;
`endif

  int total;
  int bad;

  uart_tx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .overflow     (overflow),
`ifdef UART_TX_FIFO_LEVEL_EN
    .level        (level),
    .almost_full  (almost_full),
`endif
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_ready = 1'b0; clr_overflow = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
  endtask

  task automatic test_basic();
    wr_en = 1'b1; wr_data = 8'h41; tx_ready = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL basic_pre_valid got=%b exp=0", tx_valid); end
    step();
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b exp=1", tx_valid); end
    total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL basic_head got=%h exp=41", tx_data); end
    wr_data = 8'h42; step();
    total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL basic_no_bypass got=%h exp=41", tx_data); end
    wr_data = 8'h43; step();
    wr_en = 1'b0;
    step();
    total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL basic_stable got=%h exp=41", tx_data); end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        bad++; $display("FAIL basic_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      step();
    end
    tx_ready = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", tx_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d got=%b exp=1", i, wr_ready); end
      step();
    end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_not_ready got=%b exp=0", wr_ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf_yet got=%b exp=0", overflow); end
    wr_data = 8'hFF; step();
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b exp=1", overflow); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL full_head got=%h exp=00", tx_data); end
    // full + push + pop: pop wins, push refused
    wr_en = 1'b1; wr_data = 8'hAA; tx_ready = 1'b1;
    step();
    wr_en = 1'b0; tx_ready = 1'b0;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fullpop_ready got=%b exp=1", wr_ready); end
    total++; if (tx_data !== 8'h01) begin bad++; $display("FAIL fullpop_head got=%h exp=01", tx_data); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fullpop_ovf got=%b exp=1", overflow); end
    tx_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        bad++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(i));
      end
      step();
    end
    tx_ready = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL full_aa_dropped got=%b exp=0", tx_valid); end
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_empty_both();
    wr_en = 1'b1; wr_data = 8'h55; tx_ready = 1'b1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL eb_c0 got=%b exp=0", tx_valid); end
    step();
    wr_en = 1'b0;
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
      bad++; $display("FAIL eb_c1 got=%b/%h exp=1/55", tx_valid, tx_data);
    end
    step();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL eb_c2 got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    int pushed = 0;
    int popped = 0;
    int cycles = 0;
    while (popped < 40 && cycles < 2000) begin
      wr_en    = (pushed < 40) && (q.size() < 15) && ($urandom_range(0, 1) == 1);
      wr_data  = 8'(pushed * 7 + 3);
      tx_ready = ($urandom_range(0, 1) == 1);
      total++; if (tx_valid !== (q.size() != 0)) begin
        bad++; $display("FAIL wrap_valid got=%b exp=%b", tx_valid, q.size() != 0);
      end
      if (tx_ready && q.size() != 0) begin
        total++; if (tx_data !== q[0]) begin
          bad++; $display("FAIL wrap_data%0d got=%h exp=%h", popped, tx_data, q[0]);
        end
        void'(q.pop_front());
        popped++;
      end
      if (wr_en) begin
        q.push_back(wr_data);
        pushed++;
      end
      step();
      cycles++;
    end
    wr_en = 1'b0; tx_ready = 1'b0;
    total++; if (popped != 40) begin bad++; $display("FAIL wrap_timeout got=%0d exp=40", popped); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h90 + i); step();
    end
    wr_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0 || wr_ready !== 1'b1 || tx_data !== 8'h00) begin
      bad++; $display("FAIL rst_async got=%b/%b/%h exp=0/1/00", tx_valid, wr_ready, tx_data);
    end
    step();
    reset_n = 1'b1;
    step(); step();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_stays_empty got=%b exp=0", tx_valid); end
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); step();
    end
    clr_overflow = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", overflow); end
    step();
    clr_overflow = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b exp=0", overflow); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_full();
    test_empty_both();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
